// File: rtl/proc_io_ctrl_if.sv
// ============================================================================
//  Module      : proc_io_ctrl_if
//  Description : Bus bundle for proc_io_ctrl. It carries the processor
//                read/write ports, the per-channel producer (input) and
//                consumer (output) handshakes, and the sticky error flags.
//                The slave modport is the controller side. The master
//                modport is the environment side: processor, producers and
//                consumers.
//  Ports       : processor  proc_req_in/proc_addr_in/proc_io_in,
//                           proc_out_en/proc_addr_out/proc_io_out
//                producer   in_data/in_valid/in_ready
//                consumer   out_data/out_valid/out_ready
//                errors     err_clr/rd_empty_err/wr_ovf_err
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface proc_io_ctrl_if #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    localparam int NBW = NBMANT + NBEXPO + 1;
    // A single-channel build keeps a 1-bit address instead of a zero-width one
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic                   proc_req_in;
    logic [AIW-1:0]         proc_addr_in;
    logic [NBW-1:0]         proc_io_in;
    logic                   proc_out_en;
    logic [AOW-1:0]         proc_addr_out;
    logic [NBW-1:0]         proc_io_out;
    logic [NUIOIN*NBW-1:0]  in_data;
    logic [NUIOIN-1:0]      in_valid;
    logic [NUIOIN-1:0]      in_ready;
    logic [NUIOOU*NBW-1:0]  out_data;
    logic [NUIOOU-1:0]      out_valid;
    logic [NUIOOU-1:0]      out_ready;
    logic                   err_clr;
    logic                   rd_empty_err;
    logic                   wr_ovf_err;

    modport master (
        output proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        output in_data, in_valid, out_ready, err_clr,
        input  proc_io_in, in_ready, out_data, out_valid, rd_empty_err, wr_ovf_err
    );

    modport slave (
        input  proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        input  in_data, in_valid, out_ready, err_clr,
        output proc_io_in, in_ready, out_data, out_valid, rd_empty_err, wr_ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/proc_io_ctrl.sv
// ============================================================================
//  Module      : proc_io_ctrl
//  Description : Processor I/O controller.
//                Input side: each channel has one holding register and a full
//                flag. A producer loads the register while it is empty. The
//                processor reads it combinationally by address, and the read
//                strobe empties it.
//                Output side: each channel has one data register and a valid
//                flag. A processor write fills the register. A consumer
//                handshake drains it.
//                Sticky flags record reads of empty channels and overwrites
//                of output data that has not yet been consumed.
//  Ports       : clk          - clock, rising edge
//                rst          - synchronous reset, active low
//                bus (slave)  - processor, producer, consumer and error
//                               signals (see proc_io_ctrl_if)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_io_ctrl #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
) (
    input  logic              clk,
    input  logic              rst,
    proc_io_ctrl_if.slave     bus
);
    localparam int NBW = NBMANT + NBEXPO + 1;
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    // Channel counts widened by one bit so that an address can be compared
    // against a count that is an exact power of two.
    localparam logic [AIW:0] c_NIN = (AIW+1)'(NUIOIN);
    localparam logic [AOW:0] c_NOU = (AOW+1)'(NUIOOU);

    // ------------------------------------------------------------------
    // Address qualification
    // ------------------------------------------------------------------
    logic w_rd_addr_ok;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_rd_addr_ok = ({1'b0, bus.proc_addr_in} < c_NIN);
    assign w_rd_ok      = bus.proc_req_in && w_rd_addr_ok;
    assign w_wr_ok      = bus.proc_out_en && ({1'b0, bus.proc_addr_out} < c_NOU);

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    logic [NUIOIN-1:0]     w_fin;
    logic [NUIOIN-1:0]     w_rd_sel;
    logic [NUIOIN*NBW-1:0] w_hin_flat;

    generate
        for (genvar k = 0; k < NUIOIN; k++) begin : g_in
            logic           r_fin;
            logic [NBW-1:0] r_hin;
            logic           w_load;

            assign w_rd_sel[k] = w_rd_ok && (bus.proc_addr_in == AIW'(k));
            // Loads are accepted only into an empty register. A full channel
            // cannot load and be read on the same edge.
            assign w_load      = bus.in_valid[k] && !r_fin;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_fin <= 1'b0;
                    r_hin <= '0;
                end else if (w_load) begin
                    // An empty-channel read on the same edge does not discard
                    // the arriving word.
                    r_fin <= 1'b1;
                    r_hin <= bus.in_data[k*NBW +: NBW];
                end else if (w_rd_sel[k]) begin
                    r_fin <= 1'b0;
                end
            end

            assign w_fin[k]                  = r_fin;
            assign w_hin_flat[k*NBW +: NBW]  = r_hin;
        end
    endgenerate

    assign bus.in_ready   = ~w_fin;
    assign bus.proc_io_in = w_rd_addr_ok ? w_hin_flat[int'(bus.proc_addr_in)*NBW +: NBW]
                                         : '0;

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    logic [NUIOOU-1:0] w_ov;
    logic [NUIOOU-1:0] w_ovf_hit;

    generate
        for (genvar j = 0; j < NUIOOU; j++) begin : g_out
            logic           r_ov;
            logic [NBW-1:0] r_hout;
            logic           w_wr_sel;

            assign w_wr_sel = w_wr_ok && (bus.proc_addr_out == AOW'(j));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_ov   <= 1'b0;
                    r_hout <= '0;
                end else if (w_wr_sel) begin
                    // The write wins over a coincident transfer, so valid stays set
                    r_ov   <= 1'b1;
                    r_hout <= bus.proc_io_out;
                end else if (r_ov && bus.out_ready[j]) begin
                    r_ov   <= 1'b0;
                end
            end

            // Data is lost only when the consumer is not taking it this edge
            assign w_ovf_hit[j]               = w_wr_sel && r_ov && !bus.out_ready[j];
            assign w_ov[j]                    = r_ov;
            assign bus.out_data[j*NBW +: NBW] = r_hout;
        end
    endgenerate

    assign bus.out_valid = w_ov;

    // ------------------------------------------------------------------
    // Sticky error flags: a new event on the clear edge keeps the flag set
    // ------------------------------------------------------------------
    logic w_rd_empty_hit;
    logic r_rd_empty_err;
    logic r_wr_ovf_err;

    assign w_rd_empty_hit = |(w_rd_sel & ~w_fin);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_empty_err <= 1'b0;
            r_wr_ovf_err   <= 1'b0;
        end else begin
            if (w_rd_empty_hit)
                r_rd_empty_err <= 1'b1;
            else if (bus.err_clr)
                r_rd_empty_err <= 1'b0;

            if (|w_ovf_hit)
                r_wr_ovf_err <= 1'b1;
            else if (bus.err_clr)
                r_wr_ovf_err <= 1'b0;
        end
    end

    assign bus.rd_empty_err = r_rd_empty_err;
    assign bus.wr_ovf_err   = r_wr_ovf_err;

endmodule

`default_nettype wire
